// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: writeback source select, load size and
// writeback stage state encoding.
package cpu_pkg;

    typedef enum logic {
        WB_ALU  = 1'b0,
        WB_LOAD = 1'b1
    } wb_sel_t;

    // Encoding 2'b11 has no name and is handled as a word load.
    typedef enum logic [1:0] {
        LD_WORD = 2'b00,
        LD_HALF = 2'b01,
        LD_BYTE = 2'b10
    } ld_size_t;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Load data lane select and sign/zero extension (purely combinational).
module load_extend
    import cpu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  ld_size_t    size,
    input  logic        is_signed,
    output logic [31:0] result
);

    logic [15:0] half_lane;
    logic [7:0]  byte_lane;

    // Pick the addressed halfword and byte from the little-endian word.
    always_comb begin
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
        case (addr)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
    end

    // Extend the selected lane; words (and the unused 2'b11 size) pass through.
    always_comb begin
        case (size)
            LD_HALF: result = is_signed ? {{16{half_lane[15]}}, half_lane}
                                        : {16'h0000, half_lane};
            LD_BYTE: result = is_signed ? {{24{byte_lane[7]}}, byte_lane}
                                        : {24'h000000, byte_lane};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/wb_writeback.sv
// Writeback stage: owns the register-file write port. ALU results are written
// the cycle after acceptance; loads wait for memory read data (bounded by a
// timeout), then are lane-selected and extended before the write.
module wb_writeback
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_reg_wr,
    input  logic        in_wb_sel,
    input  logic [3:0]  in_reg_dst,
    input  logic [31:0] in_alu_result,
    input  logic [1:0]  in_ld_size,
    input  logic        in_ld_signed,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wr,
    output logic [3:0]  wr_dst,
    output logic [31:0] wr_data,
    output logic        stall,
    output logic        err_timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    wb_state_t        state;
    logic [CNT_W-1:0] wait_cnt;
    logic [3:0]       ld_dst;
    logic             ld_wr;
    logic [1:0]       ld_addr;
    ld_size_t         ld_size;
    logic             ld_signed;
    logic [31:0]      ld_value;

    load_extend u_load_extend (
        .rdata     (mem_rdata),
        .addr      (ld_addr),
        .size      (ld_size),
        .is_signed (ld_signed),
        .result    (ld_value)
    );

    // Handshake decodes the state register only, never the in_* inputs.
    always_comb begin
        in_ready = (state == ST_IDLE);
        stall    = (state != ST_IDLE);
    end

    // Stage FSM, pending-load context, timeout counter and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            ld_dst      <= '0;
            ld_wr       <= 1'b0;
            ld_addr     <= '0;
            ld_size     <= LD_WORD;
            ld_signed   <= 1'b0;
            wr          <= 1'b0;
            wr_dst      <= '0;
            wr_data     <= '0;
            err_timeout <= 1'b0;
        end else begin
            wr          <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (wb_sel_t'(in_wb_sel) == WB_LOAD) begin
                            ld_dst    <= in_reg_dst;
                            ld_wr     <= in_reg_wr;
                            ld_addr   <= in_alu_result[1:0];
                            ld_size   <= ld_size_t'(in_ld_size);
                            ld_signed <= in_ld_signed;
                            wait_cnt  <= '0;
                            state     <= ST_WAIT_LOAD;
                        end else begin
                            wr <= in_reg_wr;
                            if (in_reg_wr) begin
                                wr_dst  <= in_reg_dst;
                                wr_data <= in_alu_result;
                            end
                        end
                    end
                end
                default: begin
                    // Read data wins over the timeout in the same cycle.
                    if (mem_rvalid) begin
                        wr    <= ld_wr;
                        state <= ST_IDLE;
                        if (ld_wr) begin
                            wr_dst  <= ld_dst;
                            wr_data <= ld_value;
                        end
                    end else if (wait_cnt == CNT_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_writeback.sv
// Self-checking bench for wb_writeback: directed scenarios plus randomized
// ALU/load traffic checked against a transaction-level reference model.
module tb_wb_writeback;

    localparam int unsigned TO = 8;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_reg_wr;
    logic        in_wb_sel;
    logic [3:0]  in_reg_dst;
    logic [31:0] in_alu_result;
    logic [1:0]  in_ld_size;
    logic        in_ld_signed;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wr;
    logic [3:0]  wr_dst;
    logic [31:0] wr_data;
    logic        stall;
    logic        err_timeout;

    int unsigned checks = 0;
    int unsigned passed = 0;

    // Last value written to the register file (outputs hold when wr=0).
    logic [3:0]  exp_dst;
    logic [31:0] exp_data;

    wb_writeback #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_reg_wr     (in_reg_wr),
        .in_wb_sel     (in_wb_sel),
        .in_reg_dst    (in_reg_dst),
        .in_alu_result (in_alu_result),
        .in_ld_size    (in_ld_size),
        .in_ld_signed  (in_ld_signed),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .wr            (wr),
        .wr_dst        (wr_dst),
        .wr_data       (wr_data),
        .stall         (stall),
        .err_timeout   (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference load result: shift the addressed lane down, mask, extend.
    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [1:0] addr,
                                             input logic [1:0] size, input logic sgn);
        int unsigned width;
        int unsigned shift;
        logic [31:0] mask;
        logic [31:0] v;
        if (size == 2'b01) begin
            width = 16;
            shift = 16 * int'(addr[1]);
        end else if (size == 2'b10) begin
            width = 8;
            shift = 8 * int'(addr);
        end else begin
            return rdata;
        end
        mask = (32'd1 << width) - 32'd1;
        v = (rdata >> shift) & mask;
        if (sgn && (((v >> (width - 1)) & 32'd1) == 32'd1))
            v = v | ~mask;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [3:0] dst, input logic [31:0] res, input logic rw);
        chk("alu_ready", in_ready, 1'b1);
        in_valid      = 1'b1;
        in_wb_sel     = 1'b0;
        in_reg_wr     = rw;
        in_reg_dst    = dst;
        in_alu_result = res;
        in_ld_size    = 2'($urandom);
        in_ld_signed  = 1'($urandom);
        tick();
        in_valid = 1'b0;
        if (rw) begin
            exp_dst  = dst;
            exp_data = res;
        end
        chk("alu_wr", wr, rw);
        chk("alu_dst", wr_dst, exp_dst);
        chk("alu_data", wr_data, exp_data);
        chk("alu_ready_after", in_ready, 1'b1);
    endtask

    // Accept a load; mem_rvalid is sampled at the k-th edge after acceptance.
    task automatic load(input logic [3:0] dst, input logic [1:0] addr, input logic [1:0] size,
                        input logic sgn, input logic [31:0] rdata, input int unsigned k,
                        input logic rw);
        chk("ld_ready", in_ready, 1'b1);
        in_valid      = 1'b1;
        in_wb_sel     = 1'b1;
        in_reg_wr     = rw;
        in_reg_dst    = dst;
        in_alu_result = {$urandom, addr} >> 0;
        in_alu_result[1:0] = addr;
        in_ld_size    = size;
        in_ld_signed  = sgn;
        tick();
        in_valid = 1'b0;
        chk("ld_stall", stall, 1'b1);
        chk("ld_wr_idle", wr, 1'b0);
        for (int i = 1; i < int'(k); i++) begin
            tick();
            chk("ld_wait_stall", stall, 1'b1);
            chk("ld_wait_err", err_timeout, 1'b0);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (rw) begin
            exp_dst  = dst;
            exp_data = ref_load(rdata, addr, size, sgn);
        end
        chk("ld_wr", wr, rw);
        chk("ld_dst", wr_dst, exp_dst);
        chk("ld_data", wr_data, exp_data);
        chk("ld_ready_after", in_ready, 1'b1);
        chk("ld_err", err_timeout, 1'b0);
    endtask

    initial begin
        int unsigned err_cycle;
        int unsigned err_count;
        int unsigned wr_count;

        rst = 1'b1;
        in_valid = 1'b0; in_reg_wr = 1'b0; in_wb_sel = 1'b0; in_reg_dst = '0;
        in_alu_result = '0; in_ld_size = '0; in_ld_signed = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        exp_dst = '0; exp_data = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_wr", wr, 1'b0);
        chk("rst_dst", wr_dst, 4'd0);
        chk("rst_data", wr_data, 32'd0);
        chk("rst_err", err_timeout, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_stall", stall, 1'b0);

        // ALU write then idle cycle with held outputs
        alu(4'd5, 32'hDEADBEEF, 1'b1);
        tick();
        chk("alu_strobe_drop", wr, 1'b0);
        chk("alu_hold_dst", wr_dst, 4'd5);
        chk("alu_hold_data", wr_data, 32'hDEADBEEF);

        // Signed byte load, lane 3, data after 3 cycles
        load(4'd7, 2'd3, 2'b10, 1'b1, 32'h80123456, 3, 1'b1);
        chk("sbyte_value", wr_data, 32'hFFFFFF80);
        // Half loads, upper lane, unsigned then signed
        load(4'd2, 2'd2, 2'b01, 1'b0, 32'h8001ABCD, 1, 1'b1);
        chk("uhalf_value", wr_data, 32'h00008001);
        load(4'd3, 2'd2, 2'b01, 1'b1, 32'h8001ABCD, 2, 1'b1);
        chk("shalf_value", wr_data, 32'hFFFF8001);
        // Size 11 behaves as word; data at the last cycle before timeout
        load(4'd9, 2'd1, 2'b11, 1'b1, 32'h89ABCDEF, TO, 1'b1);
        chk("size11_value", wr_data, 32'h89ABCDEF);
        // Load with reg_wr=0 still waits and writes nothing
        load(4'd12, 2'd0, 2'b00, 1'b0, 32'h12345678, 2, 1'b0);

        // rvalid in the acceptance cycle is ignored
        in_valid = 1'b1; in_wb_sel = 1'b1; in_reg_wr = 1'b1; in_reg_dst = 4'd4;
        in_alu_result = 32'h0; in_ld_size = 2'b00; in_ld_signed = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hBADBAD00;
        tick();
        in_valid = 1'b0; mem_rvalid = 1'b0;
        chk("accept_rvalid_wr", wr, 1'b0);
        chk("accept_rvalid_stall", stall, 1'b1);
        mem_rvalid = 1'b1; mem_rdata = 32'h0000CAFE;
        tick();
        mem_rvalid = 1'b0;
        exp_dst = 4'd4; exp_data = 32'h0000CAFE;
        chk("accept_rvalid_late_wr", wr, 1'b1);
        chk("accept_rvalid_late_data", wr_data, exp_data);

        // Timeout: no response
        in_valid = 1'b1; in_wb_sel = 1'b1; in_reg_wr = 1'b1; in_reg_dst = 4'd8;
        in_ld_size = 2'b00;
        tick();
        in_valid = 1'b0;
        err_cycle = 0; err_count = 0; wr_count = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (wr) wr_count++;
            if (err_timeout) begin
                err_count++;
                err_cycle = i;
                chk("to_ready_with_err", in_ready, 1'b1);
            end
        end
        chk("to_cycle", err_cycle, TO);
        chk("to_count", err_count, 1);
        chk("to_no_write", wr_count, 0);
        chk("to_ready", in_ready, 1'b1);
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
        tick();
        mem_rvalid = 1'b0;
        chk("stray_rvalid_wr", wr, 1'b0);
        chk("stray_rvalid_data", wr_data, exp_data);

        // Four back-to-back ALU ops, second has reg_wr=0
        alu(4'd1, 32'h11111111, 1'b1);
        alu(4'd2, 32'h22222222, 1'b0);
        chk("b2b_hold_dst", wr_dst, 4'd1);
        alu(4'd3, 32'h33333333, 1'b1);
        alu(4'd4, 32'h44444444, 1'b1);
        tick();
        chk("b2b_end", wr, 1'b0);

        // Randomized traffic, minimum load-to-accept spacing included
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(1, 0) == 1)
                alu(4'($urandom), $urandom, 1'($urandom_range(3, 0) != 0));
            else
                load(4'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), $urandom,
                     $urandom_range(TO, 1), 1'($urandom_range(3, 0) != 0));
        end

        // Reset during WAIT_LOAD drops the load
        in_valid = 1'b1; in_wb_sel = 1'b1; in_reg_wr = 1'b1; in_reg_dst = 4'd6;
        in_ld_size = 2'b00;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_wr", wr, 1'b0);
        chk("midrst_dst", wr_dst, 4'd0);
        chk("midrst_data", wr_data, 32'd0);
        chk("midrst_err", err_timeout, 1'b0);
        chk("midrst_ready", in_ready, 1'b1);
        mem_rvalid = 1'b1; mem_rdata = 32'h5A5A5A5A;
        tick();
        mem_rvalid = 1'b0;
        chk("midrst_rvalid_wr", wr, 1'b0);
        chk("midrst_rvalid_data", wr_data, 32'd0);
        chk("midrst_rvalid_ready", in_ready, 1'b1);
        for (int i = 0; i < int'(TO) + 2; i++) begin
            tick();
            chk("midrst_no_err", err_timeout, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/wb_writeback.md
# wb_writeback

Writeback stage of the pipeline: accepts retiring instructions from the MEM/WB boundary and owns the single register-file write port. It drives `wr`/`wr_dst`/`wr_data` into ID, which feed the register file and the ID bypass. ALU results are written one cycle after acceptance. Loads wait for variable-latency memory read data, then lane-select and extend it before writing; a timeout guards against a memory that never responds.

## Interface
- `TIMEOUT_CYCLES`, 64: cycles waited for `mem_rvalid` before abandoning a load.
- `clk`  input  1  clock.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  retiring instruction present.
- `in_ready`  output  1  stage can accept; upstream holds all `in_*` while `in_valid & !in_ready`.
- `in_reg_wr`  input  1  instruction writes a register.
- `in_wb_sel`  input  1  0 = ALU result, 1 = load data.
- `in_reg_dst`  input  4  destination register.
- `in_alu_result`  input  32  ALU result; for loads, the byte address (bits [1:0] used).
- `in_ld_size`  input  2  00 = word, 01 = half, 10 = byte.
- `in_ld_signed`  input  1  sign-extend half/byte loads when 1, else zero-extend.
- `mem_rvalid`  input  1  load data valid, single-cycle pulse.
- `mem_rdata`  input  32  load data word, little-endian.
- `wr`  output  1  register write strobe to ID.
- `wr_dst`  output  4  write destination.
- `wr_data`  output  32  write data.
- `stall`  output  1  equals `!in_ready`.
- `err_timeout`  output  1  one-cycle pulse when a load is abandoned.

## Operation
- States: IDLE, WAIT_LOAD. `in_ready = (state == IDLE)`.
- IDLE, accept with `in_wb_sel=0`: register `wr=in_reg_wr`, `wr_dst=in_reg_dst`, `wr_data=in_alu_result`. Stay in IDLE.
- IDLE, accept with `in_wb_sel=1`: latch `reg_dst`, `reg_wr`, `addr[1:0]`, size, signedness. Clear the timeout counter and go to WAIT_LOAD. `wr=0` next cycle.
- `in_valid` with `in_reg_wr=0`: accepted normally; `wr` stays 0. A load with `reg_wr=0` still waits for its data.
- WAIT_LOAD, `mem_rvalid=1`: write the extended data (`wr`=latched `reg_wr`) and go to IDLE. The counter is not checked in that cycle.
- WAIT_LOAD, no `mem_rvalid`: increment the counter. When the counter reaches `TIMEOUT_CYCLES-1`, pulse `err_timeout`, perform no write, and go to IDLE.
- `mem_rvalid` in IDLE, including the acceptance cycle of a load, is ignored.
- Lane select:
  - word: whole `mem_rdata`, address bits ignored.
  - half: `addr[1]` selects [15:0] or [31:16].
  - byte: `addr[1:0]` selects the byte lane.
  - then sign- or zero-extend to 32 bits.
- `in_ld_size=11`: treated as word.
- `wr` is a one-cycle strobe. `wr_dst`/`wr_data` hold their last value when `wr=0`.

## Timing
- Reset values: state IDLE, `wr=0`, `wr_dst=0`, `wr_data=0`, `err_timeout=0`, counter 0. Hence `in_ready=1` and `stall=0` in the first cycle after reset.
- ALU path: accepted at edge T -> `wr` high during cycle T..T+1. Back-to-back acceptance every cycle gives a continuous write stream.
- Load path: accepted at edge T. The first `mem_rvalid` sampled at edge T+k (k>=1) -> `wr` high in the cycle after edge T+k, and `in_ready` is 1 in that same cycle. Minimum load-to-next-accept is 2 cycles.
- Timeout: with no response, `err_timeout` is high in the cycle after edge T+`TIMEOUT_CYCLES`, and `in_ready` returns to 1 together with it.
- `rst` asserted mid-load: the pending load is dropped, with no write and no `err_timeout`. A `mem_rvalid` arriving after reset is ignored.
- All outputs except `in_ready`/`stall` are registered. `in_ready`/`stall` decode the state register only, never the `in_*` inputs.

## Structure
- Shared package `cpu_pkg`:
  - `wb_sel_t` (ALU/LOAD).
  - `ld_size_t` (WORD/HALF/BYTE).
  - `wb_state_t` (IDLE/WAIT_LOAD).
- Counter width: `$clog2(TIMEOUT_CYCLES)+1`, local to the block.
- One combinational sub-module, `load_extend`:
  - inputs `rdata`, `addr[1:0]`, `size`, `signed`.
  - output: 32-bit extended value.

## Test plan
- Reset, then ALU accept with `reg_dst=5`, `result=0xDEADBEEF` -> next cycle `wr=1`, `wr_dst=5`, `wr_data=0xDEADBEEF`. Following cycle `wr=0`.
- Signed byte load with `addr=0x…3`, `rdata=0x80123456`, `rvalid` 3 cycles later -> `stall=1` for 3 cycles, then `wr=1` with `wr_data=0xFFFFFF80`.
- Unsigned half load with `addr[1]=1`, `rdata=0x8001ABCD` -> `wr_data=0x00008001`. Same load with signed set -> `0xFFFF8001`.
- Load with no `rvalid` and `TIMEOUT_CYCLES=8` -> `err_timeout` pulses once, `wr` never asserts, `in_ready` returns to 1. A later stray `rvalid` causes no write.
- Four ALU instructions on consecutive cycles, the 2nd with `reg_wr=0` -> `wr` reads 1,0,1,1 on consecutive cycles with the matching `wr_dst`.
- `rst` pulsed during WAIT_LOAD, then `rvalid` -> no write, outputs at reset values, `in_ready=1`.
